// File: rtl/audio_pkg.sv
// Shared audio-path types and constants for the codec interface blocks.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef struct packed {
    logic signed [15:0] left;
    logic signed [15:0] right;
  } stereo_t;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    LEFT,
    RIGHT
  } dac_state_t;

endpackage

// File: rtl/edge_sync.sv
// Multi-stage synchronizer for an asynchronous codec clock, giving the synchronized level
// and a one-cycle pulse on every change of that level.
module edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic Clk,
  input  logic reset,
  input  logic sig_i,
  output logic level_o,
  output logic edge_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic [STAGES:0]   arm_q;

  always_ff @(posedge Clk) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], sig_i};
      prev_q <= sync_q[STAGES-1];
      arm_q  <= {arm_q[STAGES-1:0], 1'b1};
    end
  end

  assign level_o = sync_q[STAGES-1];
  // Edges stay masked until the chain has flushed after reset, so a level that is already
  // present at reset release is not mistaken for a transition.
  assign edge_o  = arm_q[STAGES] & (sync_q[STAGES-1] ^ prev_q);

endmodule

// File: rtl/i2s_dac_serializer.sv
// Left-justified serializer for the WM8731 DAC in slave mode: latches one stereo word per
// frame and shifts each channel out MSB first on the codec's bit clock.
module i2s_dac_serializer #(
  parameter int unsigned SAMPLE_W    = audio_pkg::SAMPLE_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [2*SAMPLE_W-1:0] data_in,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  sample_req,
  output logic                  frame_err
);

  import audio_pkg::*;

  localparam int unsigned    CntW    = $clog2(SAMPLE_W + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(SAMPLE_W);

  dac_state_t          state_q, state_d;
  logic [SAMPLE_W-1:0] hold_q, hold_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                dacdat_q, dacdat_d;
  logic                err_q, err_d;

  logic bclk_level, bclk_edge, lr_level, lr_edge;
  logic bclk_fall, lr_rise, lr_fall;

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_bclk_sync (
    .Clk     (Clk),
    .reset   (reset),
    .sig_i   (AUD_BCLK),
    .level_o (bclk_level),
    .edge_o  (bclk_edge)
  );

  edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lrck_sync (
    .Clk     (Clk),
    .reset   (reset),
    .sig_i   (AUD_DACLRCK),
    .level_o (lr_level),
    .edge_o  (lr_edge)
  );

  assign bclk_fall = bclk_edge & ~bclk_level;
  assign lr_rise   = lr_edge & lr_level;
  assign lr_fall   = lr_edge & ~lr_level;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    dacdat_d  = dacdat_q;
    err_d     = err_q;

    // An LR edge takes priority and absorbs any BCLK fall seen in the same cycle.
    if (lr_rise) begin
      if (state_q != WAIT_SYNC && bit_cnt_q < CntFull) err_d = 1'b1;
      state_d   = LEFT;
      hold_d    = data_in[SAMPLE_W-1:0];
      shift_d   = data_in[2*SAMPLE_W-1 -: SAMPLE_W];
      dacdat_d  = data_in[2*SAMPLE_W-1];
      bit_cnt_d = CntW'(1);
    end else if (lr_fall && state_q != WAIT_SYNC) begin
      if (bit_cnt_q < CntFull) err_d = 1'b1;
      state_d   = RIGHT;
      shift_d   = hold_q;
      dacdat_d  = hold_q[SAMPLE_W-1];
      bit_cnt_d = CntW'(1);
    end else if (bclk_fall && state_q != WAIT_SYNC) begin
      if (bit_cnt_q < CntFull) begin
        shift_d   = shift_q << 1;
        dacdat_d  = shift_q[SAMPLE_W-2];
        bit_cnt_d = bit_cnt_q + 1'b1;
      end else begin
        dacdat_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q   <= WAIT_SYNC;
      hold_q    <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      dacdat_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      dacdat_q  <= dacdat_d;
      err_q     <= err_d;
    end
  end

  assign AUD_DACDAT = dacdat_q;
  assign frame_err  = err_q;
  assign sample_req = reset & lr_rise;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// Bench for i2s_dac_serializer: drives codec-style BCLK/LRCK frames and checks every bit the
// codec would sample against a frame-level model, plus literal per-channel expectations.
module tb_i2s_dac_serializer;

  localparam int W = 16;

  logic        Clk         = 1'b0;
  logic        reset       = 1'b0;
  logic        AUD_BCLK    = 1'b1;
  logic        AUD_DACLRCK = 1'b0;
  logic [31:0] data_in     = 32'hA5F0_0F5A;
  logic        AUD_DACDAT, sample_req, frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level model of what the codec should receive.
  bit          m_active  = 1'b0;
  bit          m_err     = 1'b0;
  logic [31:0] m_word    = '0;
  logic [15:0] m_cur     = '0;
  int          m_half_nb = 0;
  int          m_sreq    = 0;

  int          bit_idx   = -1;
  logic [15:0] cap       = '0;
  int          sreq_cnt  = 0;
  bit          rst_q     = 1'b1;

  i2s_dac_serializer #(
    .SAMPLE_W    (16),
    .SYNC_STAGES (2)
  ) dut (
    .Clk         (Clk),
    .reset       (reset),
    .data_in     (data_in),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK),
    .AUD_DACDAT  (AUD_DACDAT),
    .sample_req  (sample_req),
    .frame_err   (frame_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk) rst_q <= reset;

  always @(negedge Clk) begin
    if (sample_req === 1'b1) sreq_cnt++;
    if (!rst_q) begin
      chk("rst_dacdat", 32'(AUD_DACDAT), 32'h0);
      chk("rst_sample_req", 32'(sample_req), 32'h0);
      chk("rst_frame_err", 32'(frame_err), 32'h0);
    end
  end

  // The codec's view: sample DACDAT on every BCLK rise.
  always @(posedge AUD_BCLK) begin
    logic e;
    if (bit_idx >= 0) begin
      e = 1'b0;
      if (m_active && bit_idx < W) e = m_cur[W-1-bit_idx];
      chk("dacdat_bit", 32'(AUD_DACDAT), 32'(e));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      if (bit_idx == 0) cap = '0;
      if (bit_idx < W) cap[W-1-bit_idx] = AUD_DACDAT;
    end
  end

  // One LR half of nb BCLK periods (16 Clk each); LR toggles together with the first BCLK fall.
  task automatic half(input bit lr, input int nb, input int chg_at, input logic [31:0] chg_val,
                      input int rst_at);
    for (int b = 0; b < nb; b++) begin
      @(negedge Clk);
      AUD_BCLK = 1'b0;
      if (b == 0) begin
        if (m_active && m_half_nb < W) m_err = 1'b1;
        m_half_nb = nb;
        if (lr && reset) begin
          m_active = 1'b1;
          m_word   = data_in;
          m_cur    = m_word[31:16];
          m_sreq++;
        end else if (!lr && m_active) begin
          m_cur = m_word[15:0];
        end
        AUD_DACLRCK = lr;
      end
      if (b == chg_at) data_in = chg_val;
      if (b == rst_at) begin
        reset    = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        repeat (5) @(negedge Clk);
      end else begin
        repeat (8) @(negedge Clk);
      end
      bit_idx  = b;
      AUD_BCLK = 1'b1;
      repeat (7) @(negedge Clk);
    end
  endtask

  initial begin
    // Reset held while the codec clocks run.
    half(1'b1, 2, -1, '0, -1);
    half(1'b0, 2, -1, '0, -1);
    @(negedge Clk);
    reset = 1'b1;
    repeat (8) @(negedge Clk);

    // Full frame of 32 BCLK per half.
    half(1'b1, 32, -1, '0, -1);
    chk("left_A5F0", 32'(cap), 32'hA5F0);
    half(1'b0, 32, -1, '0, -1);
    chk("right_0F5A", 32'(cap), 32'h0F5A);
    chk("err_after_full_frame", 32'(frame_err), 32'h0);
    chk("sreq_count_1", 32'(sreq_cnt), 32'd1);

    // data_in changes mid-left; right half must still come from the latched word.
    half(1'b1, 32, 5, 32'h1234_5678, -1);
    chk("left_before_change", 32'(cap), 32'hA5F0);
    half(1'b0, 32, -1, '0, -1);
    chk("right_from_hold", 32'(cap), 32'h0F5A);
    half(1'b1, 32, -1, '0, -1);
    chk("left_1234", 32'(cap), 32'h1234);
    half(1'b0, 32, 5, 32'hA5F0_0F5A, -1);
    chk("right_5678", 32'(cap), 32'h5678);
    chk("sreq_count_3", 32'(sreq_cnt), 32'd3);

    // Short halves of 10 BCLK: only the 10 MSBs go out, frame_err latches.
    half(1'b1, 10, -1, '0, -1);
    chk("short_left", 32'(cap), 32'hA5C0);
    chk("err_before_short_end", 32'(frame_err), 32'h0);
    half(1'b0, 10, -1, '0, -1);
    chk("short_right", 32'(cap), 32'h0F40);
    chk("err_after_short", 32'(frame_err), 32'h1);
    half(1'b1, 32, -1, '0, -1);
    chk("left_after_short", 32'(cap), 32'hA5F0);
    half(1'b0, 32, -1, '0, -1);
    chk("right_after_short", 32'(cap), 32'h0F5A);
    chk("err_sticky", 32'(frame_err), 32'h1);

    // Reset mid-left, then an LR fall that must be ignored, then a clean frame.
    half(1'b1, 32, -1, '0, 4);
    chk("err_cleared_by_reset", 32'(frame_err), 32'h0);
    half(1'b0, 32, -1, '0, -1);
    chk("right_suppressed", 32'(cap), 32'h0);
    chk("sreq_count_6", 32'(sreq_cnt), 32'd6);
    half(1'b1, 32, -1, '0, -1);
    chk("left_after_reset", 32'(cap), 32'hA5F0);
    half(1'b0, 32, -1, '0, -1);
    chk("right_after_reset", 32'(cap), 32'h0F5A);
    chk("sreq_count_7", 32'(sreq_cnt), 32'd7);
    chk("sreq_vs_model", 32'(sreq_cnt), 32'(m_sreq));

    repeat (4) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
